// File: rtl/interp_op_seq.sv
// interp_op_seq: time-interpolation sequencer/accumulator for NRS channel estimation.
//
// Captures pilot estimates E1/E3/E4 on an accepted start and walks a fixed nine-state
// schedule. Each state drives a 3-bit operand-select code that picks one operand for a
// single signed add per cycle. The two results are:
//   y_a = E1 + 2*E4 - 2*E3
//   y_b = (5*E3 + 2*E4 + 1) >>> 1   (arithmetic floor shift)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      run request, sampled only in IDLE
//   E1/E3/E4   signed pilot estimates (IN_WIDTH), captured when start is accepted
//   busy       high from LOAD through DONE
//   sel        current operand-select code (observe only)
//   y_a/y_b    signed results (OUT_WIDTH), held until the next update
//   out_valid  one-cycle pulse while in DONE
//
// Build option:
//   INTERP_SAT_EN  when defined, results saturate to the OUT_WIDTH signed range;
//                  otherwise they wrap (low OUT_WIDTH bits kept).
module interp_op_seq #(
  parameter int unsigned IN_WIDTH  = 17,
  parameter int unsigned OUT_WIDTH = 19
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic signed [IN_WIDTH-1:0]  E1,
  input  logic signed [IN_WIDTH-1:0]  E3,
  input  logic signed [IN_WIDTH-1:0]  E4,
  output logic                        busy,
  output logic [2:0]                  sel,
  output logic signed [OUT_WIDTH-1:0] y_a,
  output logic signed [OUT_WIDTH-1:0] y_b,
  output logic                        out_valid
);

  localparam int unsigned AccW = OUT_WIDTH + 1;
  // One bit wider than 2*E so that -(2*most-negative E3) stays representable.
  localparam int unsigned R2W  = IN_WIDTH + 2;

  localparam logic [2:0] SelOne  = 3'b000;
  localparam logic [2:0] Sel2E3  = 3'b001;
  localparam logic [2:0] Sel2E4  = 3'b011;
  localparam logic [2:0] Sel5E   = 3'b010;
  localparam logic [2:0] SelE1   = 3'b110;
  localparam logic [2:0] Sel2E   = 3'b100;
  localparam logic [2:0] SelNone = 3'b111;

  typedef enum logic [3:0] {
    StIdle, StLoad, StA1, StA2, StA3, StB1, StB2, StB3, StDone
  } state_e;

  state_e                     state_q;
  logic [2:0]                 sel_q;
  logic                       busy_q;
  logic                       out_valid_q;
  logic signed [IN_WIDTH-1:0] e1_q, e3_q, e4_q;
  logic signed [R2W-1:0]      reg_2e_q;
  logic signed [AccW-1:0]     reg_5e_q;
  logic signed [AccW-1:0]     acc_q;
  logic signed [OUT_WIDTH-1:0] y_a_q, y_b_q;

  logic signed [AccW-1:0]     operand;
  logic signed [AccW-1:0]     sum;
  logic signed [AccW-1:0]     sum_half;

  // Narrow the accumulator-width value to the output width.
  function automatic logic signed [OUT_WIDTH-1:0] fit(input logic signed [AccW-1:0] v);
`ifdef INTERP_SAT_EN
    // Only one extra bit, so overflow shows up as disagreeing top two bits.
    if (v[AccW-1] != v[AccW-2]) begin
      fit = v[AccW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else begin
      fit = OUT_WIDTH'(v);
    end
`else
    fit = OUT_WIDTH'(v);
`endif
  endfunction

  // Operand decode driven by the registered select code of the current state.
  always_comb begin
    operand = '0;
    case (sel_q)
      SelOne:  operand = AccW'(1);
      Sel2E3:  operand = AccW'(e3_q) <<< 1;
      Sel2E4:  operand = AccW'(e4_q) <<< 1;
      Sel5E:   operand = reg_5e_q;
      SelE1:   operand = AccW'(e1_q);
      Sel2E:   operand = AccW'(reg_2e_q);
      default: operand = '0;
    endcase
  end

  assign sum      = acc_q + operand;
  assign sum_half = sum >>> 1;

  // Single FSM block; sel/busy/out_valid are registered alongside the state so that
  // sel_q always carries the code belonging to state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sel_q       <= SelNone;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      e1_q        <= '0;
      e3_q        <= '0;
      e4_q        <= '0;
      reg_2e_q    <= '0;
      reg_5e_q    <= '0;
      acc_q       <= '0;
      y_a_q       <= '0;
      y_b_q       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          sel_q <= SelNone;
          if (start) begin
            e1_q    <= E1;
            e3_q    <= E3;
            e4_q    <= E4;
            busy_q  <= 1'b1;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          reg_2e_q <= -(R2W'(e3_q) <<< 1);
          reg_5e_q <= (AccW'(e3_q) <<< 2) + AccW'(e3_q);
          sel_q    <= SelE1;
          state_q  <= StA1;
        end
        StA1: begin
          acc_q   <= operand;
          sel_q   <= Sel2E4;
          state_q <= StA2;
        end
        StA2: begin
          acc_q   <= sum;
          sel_q   <= Sel2E;
          state_q <= StA3;
        end
        StA3: begin
          acc_q   <= sum;
          y_a_q   <= fit(sum);
          sel_q   <= Sel5E;
          state_q <= StB1;
        end
        StB1: begin
          acc_q   <= operand;
          sel_q   <= Sel2E4;
          state_q <= StB2;
        end
        StB2: begin
          acc_q   <= sum;
          sel_q   <= SelOne;
          state_q <= StB3;
        end
        StB3: begin
          acc_q       <= sum;
          y_b_q       <= fit(sum_half);
          sel_q       <= SelNone;
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          busy_q  <= 1'b0;
          sel_q   <= SelNone;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          sel_q   <= SelNone;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign sel       = sel_q;
  assign y_a       = y_a_q;
  assign y_b       = y_b_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_interp_op_seq.sv
// Self-checking bench for interp_op_seq: directed and random runs compared against an
// arithmetic reference of the interpolation formulas.
module tb_interp_op_seq;

  localparam int IW = 17;
  localparam int OW = 19;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic signed [IW-1:0] e1, e3, e4;
  logic                 busy;
  logic [2:0]           sel;
  logic signed [OW-1:0] y_a, y_b;
  logic                 out_valid;

  int vectors     = 0;
  int miscompares = 0;

  logic signed [IW-1:0] r1, r2, r3;

  // Expected select codes from LOAD through DONE.
  logic [2:0] sel_seq [8] = '{3'b111, 3'b110, 3'b011, 3'b100, 3'b010, 3'b011, 3'b000, 3'b111};

  always #5 clk = ~clk;

  interp_op_seq #(
    .IN_WIDTH (IW),
    .OUT_WIDTH(OW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .E1       (e1),
    .E3       (e3),
    .E4       (e4),
    .busy     (busy),
    .sel      (sel),
    .y_a      (y_a),
    .y_b      (y_b),
    .out_valid(out_valid)
  );

  function automatic longint fit_model(input longint x);
`ifdef INTERP_SAT_EN
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (OW - 1)) - 1;
    lo = -(longint'(1) <<< (OW - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
`else
    longint m;
    m = x & ((longint'(1) <<< OW) - 1);
    if (m >= (longint'(1) <<< (OW - 1))) m = m - (longint'(1) <<< OW);
    return m;
`endif
  endfunction

  function automatic longint ya_model(input longint a, input longint b, input longint c);
    return fit_model(a + 2 * c - 2 * b);
  endfunction

  function automatic longint yb_model(input longint b, input longint c);
    longint s;
    s = 5 * b + 2 * c + 1;
    // Floor division by two, also for negative sums.
    if (s < 0 && (s % 2) != 0) return fit_model((s - 1) / 2);
    return fit_model(s / 2);
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full run; optionally raises start again (with junk data) while in step repulse.
  task automatic run(input longint a, input longint b, input longint c, input int repulse);
    e1    = IW'(a);
    e3    = IW'(b);
    e4    = IW'(c);
    start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == repulse) begin
        start = 1'b1;
        e1    = IW'(-a);
        e3    = IW'(c);
        e4    = IW'(b);
      end else begin
        start = 1'b0;
      end
      chk("sel", sel, sel_seq[k]);
      chk("busy", busy, 1'b1);
      chk("out_valid", out_valid, k == 7);
    end
    chk("y_a", y_a, ya_model(a, b, c));
    chk("y_b", y_b, yb_model(b, c));
    tick();
    chk("busy_after", busy, 1'b0);
    chk("valid_after", out_valid, 1'b0);
    chk("sel_after", sel, 3'b111);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    e1    = '0;
    e3    = '0;
    e4    = '0;
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_sel", sel, 3'b111);
    chk("rst_y_a", y_a, 0);
    chk("rst_y_b", y_b, 0);
    rst_n = 1'b1;
    tick();

    // Basic directed vectors, with literal results as well as the model.
    run(100, 10, 20, -1);
    chk("t1_y_a", y_a, 120);
    chk("t1_y_b", y_b, 45);
    run(-5, -3, 7, -1);
    chk("t2_y_a", y_a, 15);
    chk("t2_y_b", y_b, 0);
    run(65535, -65536, 65535, -1);
`ifdef INTERP_SAT_EN
    chk("t3_y_a", y_a, 262143);
`else
    chk("t3_y_a", y_a, -196611);
`endif
    chk("t3_y_b", y_b, -98305);
    run(-65536, 65535, -65536, -1);
    run(0, 0, 0, -1);

    // start raised during A2 is ignored.
    run(1234, -567, 890, 2);

    // Asynchronous reset while in B2.
    e1    = IW'(300);
    e3    = IW'(-40);
    e4    = IW'(77);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("b2_sel", sel, 3'b011);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_sel", sel, 3'b111);
    chk("arst_y_a", y_a, 0);
    chk("arst_y_b", y_b, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("arst_hold_valid", out_valid, 1'b0);
    end
    rst_n = 1'b1;
    tick();
    run(300, -40, 77, -1);

    // start held high: back-to-back runs every nine cycles.
    e1    = IW'(-2000);
    e3    = IW'(333);
    e4    = IW'(-4444);
    start = 1'b1;
    for (int j = 0; j < 20; j++) begin
      tick();
      if ((j % 9) < 8) begin
        chk("b2b_sel", sel, sel_seq[j % 9]);
        chk("b2b_busy", busy, 1'b1);
        chk("b2b_valid", out_valid, (j % 9) == 7);
        if ((j % 9) == 7) begin
          chk("b2b_y_a", y_a, ya_model(-2000, 333, -4444));
          chk("b2b_y_b", y_b, yb_model(333, -4444));
        end
      end else begin
        chk("b2b_idle_busy", busy, 1'b0);
        chk("b2b_idle_sel", sel, 3'b111);
        chk("b2b_idle_valid", out_valid, 1'b0);
      end
    end
    start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("b2b_end_busy", busy, 1'b0);

    // Random vectors.
    for (int i = 0; i < 12; i++) begin
      r1 = IW'($urandom());
      r2 = IW'($urandom());
      r3 = IW'($urandom());
      run(r1, r2, r3, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
